// File: rtl/rr_grant_arbiter_pkg.sv
// rr_grant_arbiter shared types and constants.
// Widths, FSM state enum, one-hot to index helper.
package rr_grant_arbiter_pkg;

  localparam int N_REQ     = 16;
  localparam int REQ_IDX_W = 4;
  localparam int TMO_W     = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [REQ_IDX_W-1:0]
    oh2idx(input logic [N_REQ-1:0] oh);
    logic [REQ_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | REQ_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and arbiter.
// master: enable, req, release_req out; slave: grant, grant_valid, timeout_pulse out.
interface rr_grant_arbiter_if;
  import rr_grant_arbiter_pkg::*;

  logic             enable;
  logic [N_REQ-1:0] req;
  logic             release_req;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic             timeout_pulse;

  modport master (
    output enable, req, release_req,
    input  grant, grant_valid, timeout_pulse
  );

  modport slave (
    input  enable, req, release_req,
    output grant, grant_valid, timeout_pulse
  );

endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// rr_pick: combinational round-robin pick, first set req at or above ptr.
// Ports: req_i[15:0], ptr_i[3:0] in; pick_o[15:0] one-hot, any_req_o out.
module rr_pick
  import rr_grant_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0]     req_i,
  input  logic [REQ_IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0]     pick_o,
  output logic                 any_req_o
);

  logic [2*N_REQ-1:0] rot_dbl;
  logic [2*N_REQ-1:0] back_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   lsb;

  // Rotate so ptr sits at bit 0.
  assign rot_dbl  = {req_i, req_i} >> ptr_i;
  assign rot      = rot_dbl[N_REQ-1:0];
  // Isolate lowest set bit.
  assign lsb      = rot & (~rot + N_REQ'(1));
  // Rotate back into requester order.
  assign back_dbl = {lsb, lsb} << ptr_i;
  assign pick_o   = back_dbl[2*N_REQ-1:N_REQ];

  assign any_req_o = |req_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// 16-way round-robin arbiter with held, registered one-hot grant.
// Ports: clk, rst_n, bus (slave). Optional watchdog: WATCHDOG_TIMEOUT_EN.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
`ifdef WATCHDOG_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input logic          clk,
  input logic          rst_n,
  rr_grant_arbiter_if.slave bus
);

  state_e               state_q, state_d;
  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     pick;
  logic                 any_req;
  logic                 tmo_hit;

  rr_pick u_pick (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

`ifdef WATCHDOG_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIM =
    TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Counter is zero on the first GRANT cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT) cnt_d = cnt_q + TMO_W'(1);
  end

  assign tmo_hit = (state_q == GRANT) &&
                   (cnt_q == TMO_LIM);

  // Release and disable both mask the pulse.
  always_comb begin
    pulse_d = tmo_hit && bus.enable &&
              !bus.release_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.timeout_pulse = pulse_q;
`else
  assign tmo_hit           = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && any_req) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        unique case (1'b1)
          !bus.enable: begin
            grant_d = '0;
            state_d = IDLE;
          end
          bus.enable && (bus.release_req || tmo_hit): begin
            grant_d = '0;
            state_d = IDLE;
            ptr_d   = oh2idx(grant_q) + REQ_IDX_W'(1);
          end
          default: begin
            grant_d = grant_q;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter.
// Directed steps plus random traffic against a behavioural model.
module tb_rr_grant_arbiter;

  localparam int TMO = 4;

  logic clk;
  logic rst_n;

  rr_grant_arbiter_if bus ();

`ifdef WATCHDOG_TIMEOUT_EN
  rr_grant_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
`else
  rr_grant_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: owner index (-1 = none), priority start, hold age.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_pulse = 0;
  int m_npulse = 0;
  int d_npulse = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_grant();
    logic [15:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_pulse = 0;
  endtask

  task automatic model_edge(input logic en,
                            input logic [15:0] r,
                            input logic rel);
    m_pulse = 0;
    if (m_owner < 0) begin
      if (en && r != 0) begin
        for (int i = 0; i < 16; i++) begin
          if (m_owner < 0 && r[(m_ptr + i) % 16])
            m_owner = (m_ptr + i) % 16;
        end
        m_hold = 0;
      end
    end else if (!en) begin
      m_owner = -1;
    end else if (rel) begin
      m_ptr   = (m_owner + 1) % 16;
      m_owner = -1;
    end else begin
`ifdef WATCHDOG_TIMEOUT_EN
      if (m_hold == TMO) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
        m_pulse = 1;
        m_npulse++;
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic step(input logic en,
                      input logic [15:0] r,
                      input logic rel);
    logic [15:0] g;
    bus.enable      = en;
    bus.req         = r;
    bus.release_req = rel;
    @(posedge clk);
    model_edge(en, r, rel);
    #1;
    g = bus.grant;
    check("grant", 32'(bus.grant), 32'(m_grant()));
    check("valid", 32'(bus.grant_valid),
          32'(m_owner >= 0));
    check("pulse", 32'(bus.timeout_pulse),
          32'(m_pulse));
    check("onehot0", 32'((g & (g - 16'd1)) == 0), 32'(1));
    if (bus.timeout_pulse) d_npulse++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_valid", 32'(bus.grant_valid), 32'h0);
    check("rst_pulse", 32'(bus.timeout_pulse), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.req         = '0;
    bus.release_req = 1'b0;
    do_reset();

    // Basic grant, release, pointer advance.
    step(1, 16'h0021, 0);
    check("first", 32'(bus.grant), 32'h0001);
    step(1, 16'h0021, 1);
    check("rel", 32'(bus.grant), 32'h0);
    step(1, 16'h0021, 0);
    check("second", 32'(bus.grant), 32'h0020);
    step(1, 16'h0000, 1);

    // Full request rotation with wrap.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(1, 16'hFFFF, 0);
      check("rot", 32'(bus.grant), 32'(1) << (k % 16));
      step(1, 16'hFFFF, 0);
      step(1, 16'hFFFF, 1);
      check("rot_idle", 32'(bus.grant), 32'h0);
    end

    // Hold despite request changes.
    do_reset();
    step(1, 16'h0100, 0);
    check("hold0", 32'(bus.grant), 32'h0100);
    step(1, 16'h0008, 0);
    step(1, 16'h0008, 0);
    check("hold2", 32'(bus.grant), 32'h0100);
    step(1, 16'h0008, 1);
    step(1, 16'h0008, 0);
    check("after_hold", 32'(bus.grant), 32'h0008);
    step(1, 16'h0000, 1);

    // Enable drop keeps pointer.
    do_reset();
    step(1, 16'h0004, 0);
    check("en_g", 32'(bus.grant), 32'h0004);
    step(0, 16'h0004, 1);
    check("en_off", 32'(bus.grant), 32'h0);
    step(1, 16'h0014, 0);
    check("en_again", 32'(bus.grant), 32'h0004);

    // Asynchronous reset mid-grant.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_grant", 32'(bus.grant), 32'h0);
    check("arst_valid", 32'(bus.grant_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'h8001, 0);
    check("arst_next", 32'(bus.grant), 32'h0001);
    step(1, 16'h0000, 1);

    // Long hold without release.
    m_npulse = 0;
    d_npulse = 0;
    step(1, 16'h0002, 0);
    for (int k = 0; k < 12; k++) step(1, 16'h0002, 0);
`ifdef WATCHDOG_TIMEOUT_EN
    check("wd_pulses", 32'(d_npulse), 32'(m_npulse));
    check("wd_fired", 32'(m_npulse > 0), 32'(1));
`else
    check("nowd_hold", 32'(bus.grant), 32'h0002);
    check("nowd_pulses", 32'(d_npulse), 32'h0);
`endif
    step(1, 16'h0000, 1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      logic        en;
      logic        rel;
      logic [15:0] r;
      en  = ($urandom_range(0, 9) != 0);
      rel = ($urandom_range(0, 3) == 0);
      r   = 16'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      step(en, r, rel);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- 16-requester round-robin arbiter directly upstream of the 16-to-4 one-hot encoder.
- Produces a registered, strictly one-hot grant vector; this vector drives the encoder's 16-bit input.
- grant_valid drives the encoder enable.
- A grant is held until the owner signals release, so the encoded index stays stable for the whole transaction.

Parameters:
- N_REQ, 16, number of requesters. Fixed at 16 to match the encoder input width; other values are unsupported.
- TIMEOUT_CYCLES, 255, maximum grant hold in cycles. Used only when WATCHDOG_TIMEOUT_EN is defined. Legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  arbiter enable; low forces idle
- req  input  16  request vector, any number of bits set
- release_req  input  1  current owner finished; sampled only in GRANT
- grant  output  16  registered one-hot grant, all-zero when idle
- grant_valid  output  1  high exactly when grant is non-zero
- timeout_pulse  output  1  one-cycle pulse on watchdog-forced release; tied 0 without the macro

Behaviour:
- Reset (async assert, sync deassert by the integrator): grant=0, grant_valid=0, timeout_pulse=0, state=IDLE, ptr=0.
- State register uses two states, IDLE and GRANT. The priority pointer ptr is 4 bits.
- IDLE, with enable=1 and req!=0:
  - Select the first set req bit searching from index ptr upward, wrapping 15->0.
  - Next edge: grant is that one-hot bit, grant_valid=1, state=GRANT.
  - Latency from req to grant is 1 cycle.
- IDLE, with enable=0 or req=0: outputs stay 0 and ptr is unchanged.
- GRANT, with release_req=1 (enable=1):
  - Next edge: grant=0, grant_valid=0, state=IDLE, ptr=(granted index+1) mod 16.
  - At least one idle cycle always separates consecutive grants.
- GRANT, with release_req=0: grant is held unchanged, even if the owner's req bit drops or other req bits change. The grant is never re-evaluated mid-hold.
- GRANT, with enable=0 (takes priority over release_req): next edge grant=0, state=IDLE, ptr unchanged. The same requester wins the next arbitration if it is still requesting.
- release_req in IDLE is ignored.
- Fairness: with all 16 requests held continuously, requesters are granted in order ptr, ptr+1, ... 15, 0, ... with no starvation.
- Invariant: grant is zero or exactly one-hot at every edge, so the downstream encoder never sees a multi-hot code.
- Reset asserted mid-grant: grant clears immediately (asynchronously) and ptr returns to 0.

Optional Feature:
- Macro: WATCHDOG_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches TIMEOUT_CYCLES with release_req=0, the next edge behaves exactly as a release (grant cleared, ptr advanced) and timeout_pulse=1 for that one cycle.
  - release_req and timeout on the same cycle: treated as a normal release, timeout_pulse=0.
  - enable=0 takes priority over timeout.
- Not defined: no counter logic; timeout_pulse is constant 0 and grants can be held indefinitely.

Decomposition:
- Shared package: N_REQ, REQ_IDX_W=4, the state enum {IDLE, GRANT}, and the TIMEOUT counter width of 16.
- One sub-module, rr_pick: purely combinational. Takes req[15:0] and ptr[3:0] and returns a one-hot pick[15:0] plus any_req, using a rotate / priority-find / rotate-back structure. It is reusable by other arbiters in the design.
- The top level holds the state, ptr, the grant register and the watchdog.

Test Plan:
- Reset release, then req=16'h0021 with enable=1 → after 1 cycle grant=16'h0001, valid=1; release_req pulse → grant=0, ptr=1; next grant=16'h0020.
- req=16'hFFFF held, release_req pulsed every 3rd cycle → grants step 0001,0002,...,8000,0001 in order (wrap check), with one idle cycle between each.
- Owner in GRANT with grant=16'h0100 drops req[8] while req[3] rises, no release → grant stays 16'h0100 until release_req; then grant=16'h0008 after the idle cycle.
- enable dropped during grant=16'h0004 → next cycle grant=0, ptr unchanged; enable raised with req=16'h0014 → grant=16'h0004 again.
- rst_n asserted mid-grant (not clock-aligned) → grant and valid go 0 immediately; after release, req=16'h8001 → grant=16'h0001.
- With WATCHDOG_TIMEOUT_EN and TIMEOUT_CYCLES=4, grant held without release → timeout_pulse high for exactly 1 cycle as grant clears, ptr advances; without the macro the grant stays indefinitely and timeout_pulse stays 0.
